// File: rtl/frame_ram_ctrl.sv
// Single-port frame RAM sequencer: camera capture writes take priority, random reads are arbitrated in between.
// Optional build macro FRAME_RAM_CTRL_CONT_EN selects continuous (wrapping) capture instead of single-shot.
module frame_ram_ctrl #(
  parameter int WORD_DEPTH  = 76800,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 12,
  parameter int MAX_RD_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              cap_start_i,
  input  logic              cap_valid_i,
  input  logic [DATA_W-1:0] cap_data_i,
  output logic              cap_ready_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_adr_i,
  output logic              rd_ack_o,
  output logic [DATA_W-1:0] rd_dat_o,
  output logic              frame_done_o,
  output logic              busy_o,
  output logic              ram_we_o,
  output logic              ram_re_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [DATA_W-1:0] ram_dat_o,
  input  logic [DATA_W-1:0] ram_dat_i
);

  localparam int WAIT_W = $clog2(MAX_RD_WAIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(WORD_DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_RD_WAIT);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_cnt;
  logic [WAIT_W-1:0] rd_wait;
  logic              force_rd;
  logic              grant_wr;
  logic              grant_rd;

  // NOTE: reset is synchronous, so the combinational grants are gated with rst to keep the RAM idle during the reset cycle itself.
  always_comb begin
    force_rd    = rd_req_i & ~rd_ack_o & (rd_wait >= WAIT_MAX);
    cap_ready_o = ~rst & (state == CAPTURE) & ~force_rd & ~cap_start_i;
    grant_wr    = cap_valid_i & cap_ready_o;
    grant_rd    = ~rst & rd_req_i & ~rd_ack_o & ~grant_wr;
    ram_we_o    = grant_wr;
    ram_re_o    = grant_rd;
    ram_adr_o   = '0;
    if (!rst) ram_adr_o = grant_rd ? rd_adr_i : wr_cnt;
    busy_o      = ~rst & (state == CAPTURE);
  end

  assign rd_dat_o  = ram_dat_i;
  assign ram_dat_o = cap_data_i;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      rd_wait      <= '0;
      rd_ack_o     <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      // RAM read data is registered, so the ack lands exactly one cycle after the grant.
      rd_ack_o <= grant_rd;

      if (grant_rd || !rd_req_i)
        rd_wait <= '0;
      else if (!rd_ack_o && rd_wait < WAIT_MAX)
        rd_wait <= rd_wait + WAIT_W'(1);

`ifdef FRAME_RAM_CTRL_CONT_EN
      frame_done_o <= 1'b0;
`endif

      if (cap_start_i) begin
        state        <= CAPTURE;
        wr_cnt       <= '0;
        frame_done_o <= 1'b0;
      end else if (grant_wr) begin
        if (wr_cnt == LAST_ADR) begin
          frame_done_o <= 1'b1;
`ifdef FRAME_RAM_CTRL_CONT_EN
          wr_cnt <= '0;
`else
          state  <= DONE;
`endif
        end else begin
          wr_cnt <= wr_cnt + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_ram_ctrl.sv
// Directed bench for frame_ram_ctrl with a small frame (16 words) and a short starvation limit (4 cycles).
module tb_frame_ram_ctrl;

`ifdef FRAME_RAM_CTRL_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  localparam int N_PIX = CONT ? 32 : 16;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        cap_start_i;
  logic        cap_valid_i;
  logic [11:0] cap_data_i;
  logic        cap_ready_o;
  logic        rd_req_i;
  logic [18:0] rd_adr_i;
  logic        rd_ack_o;
  logic [11:0] rd_dat_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        ram_we_o;
  logic        ram_re_o;
  logic [18:0] ram_adr_o;
  logic [11:0] ram_dat_o;
  logic [11:0] ram_dat_i;

  logic [11:0] mem [0:31];

  int checks = 0;
  int errors = 0;

  frame_ram_ctrl #(.WORD_DEPTH(16), .ADDR_W(19), .DATA_W(12), .MAX_RD_WAIT(4)) dut (
    .clk_i(clk_i), .rst(rst),
    .cap_start_i(cap_start_i), .cap_valid_i(cap_valid_i), .cap_data_i(cap_data_i), .cap_ready_o(cap_ready_o),
    .rd_req_i(rd_req_i), .rd_adr_i(rd_adr_i), .rd_ack_o(rd_ack_o), .rd_dat_o(rd_dat_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o),
    .ram_we_o(ram_we_o), .ram_re_o(ram_re_o), .ram_adr_o(ram_adr_o),
    .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
  );

  always #5 clk_i = ~clk_i;

  // Single-port RAM model with one-cycle registered read; word 5 is seeded during reset.
  always @(posedge clk_i) begin
    if (rst) mem[5] <= 12'hABC;
    else if (ram_we_o) mem[ram_adr_o[4:0]] <= ram_dat_o;
    if (ram_re_o) ram_dat_i <= mem[ram_adr_o[4:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  initial begin
    rst = 1'b1; cap_start_i = 1'b0; cap_valid_i = 1'b1; cap_data_i = 12'h0;
    rd_req_i = 1'b1; rd_adr_i = '0;

    // Reset with both requesters active
    for (int c = 0; c < 2; c++) begin
      next_cycle(); #1;
      check("rst_we", ram_we_o, 0);
      check("rst_re", ram_re_o, 0);
      check("rst_ack", rd_ack_o, 0);
      check("rst_done", frame_done_o, 0);
      check("rst_ready", cap_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_adr", ram_adr_o, 0);
    end

    next_cycle();
    rst = 1'b0; cap_valid_i = 1'b0; rd_req_i = 1'b0; #1;
    check("idle_ready", cap_ready_o, 0);
    check("idle_busy", busy_o, 0);

    // Read latency in IDLE
    next_cycle();
    rd_req_i = 1'b1; rd_adr_i = 19'd5; #1;
    check("rd_re", ram_re_o, 1);
    check("rd_adr", ram_adr_o, 5);
    check("rd_ack_early", rd_ack_o, 0);
    next_cycle(); #1;
    check("rd_ack", rd_ack_o, 1);
    check("rd_dat", rd_dat_o, 12'hABC);
    check("rd_no_regrant", ram_re_o, 0);
    rd_req_i = 1'b0;
    next_cycle(); #1;
    check("rd_ack_pulse", rd_ack_o, 0);

    // Full frame
    next_cycle();
    cap_start_i = 1'b1; #1;
    check("start_ready", cap_ready_o, 0);
    next_cycle();
    cap_start_i = 1'b0; #1;
    check("cap_busy", busy_o, 1);
    for (int i = 0; i < N_PIX; i++) begin
      next_cycle();
      cap_valid_i = 1'b1; cap_data_i = 12'(12'h100 + (i % 16)); #1;
      check("frm_we", ram_we_o, 1);
      check("frm_adr", ram_adr_o, i % 16);
      check("frm_dat", ram_dat_o, 12'h100 + (i % 16));
      check("frm_done", frame_done_o, (CONT && i == 16) ? 1 : 0);
      check("frm_busy", busy_o, 1);
    end
    next_cycle();
    cap_data_i = 12'h110; #1;
    check("end_done", frame_done_o, 1);
    check("end_busy", busy_o, CONT ? 1 : 0);
    check("end_ready", cap_ready_o, CONT ? 1 : 0);
    check("end_we", ram_we_o, CONT ? 1 : 0);
    check("mem15", mem[15], 12'h10F);
    next_cycle();
    cap_valid_i = 1'b0; #1;
    check("done_sticky", frame_done_o, CONT ? 0 : 1);

    // Restart mid-frame after 7 writes
    next_cycle();
    cap_start_i = 1'b1; #1;
    next_cycle();
    cap_start_i = 1'b0; #1;
    check("rs_done_clr", frame_done_o, 0);
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      cap_valid_i = 1'b1; cap_data_i = 12'(12'h200 + i); #1;
      check("rs_adr", ram_adr_o, i);
    end
    next_cycle();
    cap_start_i = 1'b1; cap_data_i = 12'h2FF; #1;
    check("rs_no_we", ram_we_o, 0);
    check("rs_ready", cap_ready_o, 0);
    next_cycle();
    cap_start_i = 1'b0; cap_data_i = 12'h2AA; #1;
    check("rs_we", ram_we_o, 1);
    check("rs_adr0", ram_adr_o, 0);
    check("rs_done", frame_done_o, 0);

    // Starvation guard under a continuous capture stream
    next_cycle();
    rd_req_i = 1'b1; rd_adr_i = 19'd3;
    for (int k = 0; k < 4; k++) begin
      cap_data_i = 12'(12'h300 + k); #1;
      check("sv_we", ram_we_o, 1);
      check("sv_re", ram_re_o, 0);
      check("sv_adr", ram_adr_o, 1 + k);
      next_cycle();
    end
    cap_data_i = 12'h304; #1;
    check("sv_force_re", ram_re_o, 1);
    check("sv_force_we", ram_we_o, 0);
    check("sv_force_ready", cap_ready_o, 0);
    check("sv_force_adr", ram_adr_o, 3);
    next_cycle();
    cap_data_i = 12'h305; #1;
    check("sv_ack", rd_ack_o, 1);
    check("sv_dat", rd_dat_o, 12'h302);
    check("sv_wr_resume", ram_we_o, 1);
    check("sv_wr_cnt", ram_adr_o, 5);
    rd_req_i = 1'b0;
    next_cycle();
    cap_valid_i = 1'b0; #1;
    check("sv_ack_pulse", rd_ack_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_ram_ctrl.md
Name: frame_ram_ctrl

Overview:
Sequencer/arbiter in front of the single-port camera frame RAM (12-bit pixels, 1-cycle registered read, write-enable/read-enable/address interface). Owns the write-address counter for the camera capture stream and shares the RAM with a random-access reader (Wishbone/VGA fetch), one RAM operation per cycle. Capture writes have priority; a starvation guard bounds reader wait. Reports frame completion.

Parameters:
WORD_DEPTH, 76800, pixels per frame (320x240); last write address is WORD_DEPTH-1.
ADDR_W, 19, RAM address width.
DATA_W, 12, pixel width.
MAX_RD_WAIT, 8, max cycles a pending read may be deferred before it is forced through.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
cap_start_i  in  1  one-cycle pulse: begin (or restart) capture of a frame at address 0.
cap_valid_i  in  1  capture pixel valid.
cap_data_i  in  DATA_W  capture pixel.
cap_ready_o  out  1  capture pixel accepted this cycle when cap_valid_i&cap_ready_o.
rd_req_i  in  1  read request, held until rd_ack_o.
rd_adr_i  in  ADDR_W  read address, stable while rd_req_i high.
rd_ack_o  out  1  one-cycle pulse; rd_dat_o valid this cycle.
rd_dat_o  out  DATA_W  read data (driven from ram_dat_i).
frame_done_o  out  1  frame complete flag.
busy_o  out  1  high in CAPTURE.
ram_we_o  out  1  RAM write enable.
ram_re_o  out  1  RAM read enable.
ram_adr_o  out  ADDR_W  RAM address.
ram_dat_o  out  DATA_W  RAM write data (= cap_data_i).
ram_dat_i  in  DATA_W  RAM read data.

Behaviour:
- Reset value of every output: cap_ready_o 0, rd_ack_o 0, rd_dat_o follows ram_dat_i, frame_done_o 0, busy_o 0, ram_we_o 0, ram_re_o 0, ram_adr_o 0, ram_dat_o = cap_data_i. State IDLE, wr_cnt 0, rd_wait 0. Reset overrides every other event, including mid-capture and mid-read (pending ack dropped).
- States: IDLE (no capture), CAPTURE, DONE. IDLE/DONE --cap_start_i--> CAPTURE (wr_cnt<=0, frame_done_o<=0). CAPTURE --cap_start_i--> CAPTURE with wr_cnt<=0 (abort; any write in that cycle is suppressed). CAPTURE --write at WORD_DEPTH-1--> DONE, frame_done_o<=1 (sticky until cap_start_i or rst).
- ack_cycle = rd_ack_o. force_rd = rd_req_i & !ack_cycle & (rd_wait >= MAX_RD_WAIT).
- cap_ready_o = (state==CAPTURE) & !force_rd & !cap_start_i.
- grant_wr = cap_valid_i & cap_ready_o: ram_we_o=1, ram_adr_o=wr_cnt, wr_cnt++ next edge.
- grant_rd = rd_req_i & !ack_cycle & !grant_wr: ram_re_o=1, ram_adr_o=rd_adr_i; rd_ack_o=1 next cycle; read latency exactly 1 cycle; max rate 1 read per 2 cycles. No new read granted in the ack cycle.
- rd_wait: increments (saturating at MAX_RD_WAIT) each cycle rd_req_i & !ack_cycle & !grant_rd; clears on grant_rd or rd_req_i low.
- grant_wr and grant_rd never both 1. Neither granted: ram_adr_o=wr_cnt, we/re 0.
- Reads allowed in all states. Writes only in CAPTURE; wr_cnt never exceeds WORD_DEPTH-1.
- busy_o = (state==CAPTURE).

Optional Feature:
FRAME_RAM_CTRL_CONT_EN. Defined: continuous capture; write at WORD_DEPTH-1 wraps wr_cnt to 0, stays in CAPTURE, frame_done_o is a one-cycle pulse on the cycle after that write; DONE unreachable; cap_start_i still restarts at 0. Undefined: single-shot as above, sticky frame_done_o in DONE.

Test Plan:
- Reset: rst high 2 cycles with cap_valid_i=1, rd_req_i=1 -> ram_we_o=0, ram_re_o=0, rd_ack_o=0, frame_done_o=0, cap_ready_o=0.
- Full frame (WORD_DEPTH=16): cap_start_i, then 16 valid pixels 0x100..0x10F -> ram_we_o on addrs 0..15, frame_done_o=1 the cycle after addr 15, state DONE, 17th pixel not accepted (cap_ready_o=0).
- Read latency: in IDLE, rd_req_i with rd_adr_i=5 holding 0xABC -> ram_re_o=1 adr 5 in cycle N, rd_ack_o=1 and rd_dat_o=0xABC in N+1.
- Starvation (MAX_RD_WAIT=4): continuous capture stream plus rd_req_i -> read deferred exactly 4 cycles, then ram_re_o=1, cap_ready_o=0 for that one cycle, wr_cnt unchanged.
- Restart mid-frame: cap_start_i after 7 writes -> no write that cycle, next accepted pixel at addr 0, frame_done_o stays 0.
- With FRAME_RAM_CTRL_CONT_EN, WORD_DEPTH=16: 32 pixels -> frame_done_o pulses twice (1 cycle each), addresses 0..15,0..15, busy_o stays 1.
